// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcode values, instruction field widths,
// and small decode helper functions used by the decode stage.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;
  localparam int IMM_W   = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LB    = 6'h20;
  localparam logic [OP_W-1:0] OP_LH    = 6'h21;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU   = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OP_W-1:0] OP_SB    = 6'h28;
  localparam logic [OP_W-1:0] OP_SH    = 6'h29;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // Loads are the only instructions whose result arrives too late to forward from EX.
  function automatic logic is_mem_read(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // rt is a source (not a destination) for R-type, stores and compare-branches.
  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Logical immediates are zero-extended; everything else is sign-extended.
  function automatic logic [DATA_W-1:0] imm_ext(input logic [OP_W-1:0] op,
                                                input logic [IMM_W-1:0] imm);
    if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI))
      return {{(DATA_W-IMM_W){1'b0}}, imm};
    else
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: flags when the load sitting in ID/EX writes a
// register the instruction in decode needs to read.
import mips_pkg::*;

module hazard_detect (
  input  logic             i_id_ex_valid,
  input  logic             i_id_ex_mem_read,
  input  logic [REG_W-1:0] i_id_ex_rt,
  input  logic             i_if_valid,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_uses_rt,
  output logic             o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  // A load into $0 never produces a usable value, so it cannot create a dependency.
  always_comb begin
    w_rs_match = (i_id_ex_rt == i_rs);
    w_rt_match = i_uses_rt && (i_id_ex_rt == i_rt);
    o_hazard   = i_id_ex_valid && i_id_ex_mem_read && (i_id_ex_rt != '0) &&
                 i_if_valid && (w_rs_match || w_rt_match);
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction decode stage: register-file read addressing, same-cycle
// write-back bypass, load-use bubble insertion and the ID/EX register.
// Optional: define DECODE_STALL_CNT_EN to add the dbg_stall_count port,
// a free-running count of inserted load-use bubbles.
import mips_pkg::*;

module decode_stage (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [DATA_W-1:0]  if_instr,
  input  logic [DATA_W-1:0]  if_pc_plus4,
  input  logic               flush,
  input  logic               ex_hold,
  output logic [REG_W-1:0]   rf_read_addr1,
  output logic [REG_W-1:0]   rf_read_addr2,
  input  logic [DATA_W-1:0]  rf_read_data1,
  input  logic [DATA_W-1:0]  rf_read_data2,
  input  logic               wb_wr_enable,
  input  logic [REG_W-1:0]   wb_write_addr,
  input  logic [DATA_W-1:0]  wb_write_data,
  output logic               stall_if,
  output logic               id_ex_valid,
  output logic               id_ex_mem_read,
  output logic [DATA_W-1:0]  id_ex_rs_data,
  output logic [DATA_W-1:0]  id_ex_rt_data,
  output logic [DATA_W-1:0]  id_ex_imm,
  output logic [DATA_W-1:0]  id_ex_pc_plus4,
  output logic [REG_W-1:0]   id_ex_rs,
  output logic [REG_W-1:0]   id_ex_rt,
  output logic [REG_W-1:0]   id_ex_rd,
  output logic [SHAMT_W-1:0] id_ex_shamt,
  output logic [OP_W-1:0]    id_ex_opcode,
  output logic [FUNCT_W-1:0] id_ex_funct
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [DATA_W-1:0]  dbg_stall_count
`endif
);

  logic [OP_W-1:0]    w_opcode;
  logic [REG_W-1:0]   w_rs;
  logic [REG_W-1:0]   w_rt;
  logic [REG_W-1:0]   w_rd;
  logic [SHAMT_W-1:0] w_shamt;
  logic [FUNCT_W-1:0] w_funct;
  logic [DATA_W-1:0]  w_imm;
  logic               w_mem_read;
  logic               w_uses_rt;
  logic [DATA_W-1:0]  w_rs_data;
  logic [DATA_W-1:0]  w_rt_data;
  logic               w_hazard;

  logic               r_valid;
  logic               r_mem_read;
  logic [DATA_W-1:0]  r_rs_data;
  logic [DATA_W-1:0]  r_rt_data;
  logic [DATA_W-1:0]  r_imm;
  logic [DATA_W-1:0]  r_pc_plus4;
  logic [REG_W-1:0]   r_rs;
  logic [REG_W-1:0]   r_rt;
  logic [REG_W-1:0]   r_rd;
  logic [SHAMT_W-1:0] r_shamt;
  logic [OP_W-1:0]    r_opcode;
  logic [FUNCT_W-1:0] r_funct;

  // Field slicing and per-opcode decode of the IF/ID instruction.
  always_comb begin
    w_opcode   = if_instr[31:26];
    w_rs       = if_instr[25:21];
    w_rt       = if_instr[20:16];
    w_rd       = if_instr[15:11];
    w_shamt    = if_instr[10:6];
    w_funct    = if_instr[5:0];
    w_imm      = imm_ext(w_opcode, if_instr[15:0]);
    w_mem_read = is_mem_read(w_opcode);
    w_uses_rt  = uses_rt(w_opcode);
  end

  assign rf_read_addr1 = w_rs;
  assign rf_read_addr2 = w_rt;

  // The register file writes at the clock edge, so a same-cycle write-back
  // must be forwarded here or decode would latch the stale value.
  always_comb begin
    w_rs_data = rf_read_data1;
    w_rt_data = rf_read_data2;
    if (wb_wr_enable && (wb_write_addr != '0) && (wb_write_addr == w_rs))
      w_rs_data = wb_write_data;
    if (wb_wr_enable && (wb_write_addr != '0) && (wb_write_addr == w_rt))
      w_rt_data = wb_write_data;
  end

  hazard_detect u_hazard_detect (
    .i_id_ex_valid    (r_valid),
    .i_id_ex_mem_read (r_mem_read),
    .i_id_ex_rt       (r_rt),
    .i_if_valid       (if_valid),
    .i_rs             (w_rs),
    .i_rt             (w_rt),
    .i_uses_rt        (w_uses_rt),
    .o_hazard         (w_hazard)
  );

  // A flush kills the decode instruction outright, so fetch need not hold for it.
  assign stall_if = !flush && (ex_hold || w_hazard);

  // ID/EX register: flush > hold > bubble > load. Flush and bubble only
  // clear valid; the stale payload is ignored downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_mem_read <= 1'b0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_pc_plus4 <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
      r_opcode   <= '0;
      r_funct    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!ex_hold) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
      end else begin
        r_valid    <= if_valid;
        r_mem_read <= w_mem_read;
        r_rs_data  <= w_rs_data;
        r_rt_data  <= w_rt_data;
        r_imm      <= w_imm;
        r_pc_plus4 <= if_pc_plus4;
        r_rs       <= w_rs;
        r_rt       <= w_rt;
        r_rd       <= w_rd;
        r_shamt    <= w_shamt;
        r_opcode   <= w_opcode;
        r_funct    <= w_funct;
      end
    end
  end

  assign id_ex_valid    = r_valid;
  assign id_ex_mem_read = r_mem_read;
  assign id_ex_rs_data  = r_rs_data;
  assign id_ex_rt_data  = r_rt_data;
  assign id_ex_imm      = r_imm;
  assign id_ex_pc_plus4 = r_pc_plus4;
  assign id_ex_rs       = r_rs;
  assign id_ex_rt       = r_rt;
  assign id_ex_rd       = r_rd;
  assign id_ex_shamt    = r_shamt;
  assign id_ex_opcode   = r_opcode;
  assign id_ex_funct    = r_funct;

`ifdef DECODE_STALL_CNT_EN
  logic [DATA_W-1:0] r_stall_count;

  // Count only bubbles that actually enter ID/EX; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_count <= '0;
    else if (w_hazard && !flush && !ex_hold)
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign dbg_stall_count = r_stall_count;
`endif

endmodule
